kr_fec_parity_seq: RTL and testbench
====================================

# kr_fec_parity_seq

Sequencer for the KR-FEC parity path (generator 1+x^2+x^11+x^21+x^23+x^32). It frames the incoming stream of 65-bit transcoded words into 32-word FEC blocks and ping-pongs consecutive blocks across two `crc32_galois_d65` engine instances. It clears each engine between blocks, captures the 32-bit parity when a block completes, and reports framing errors. It sits between the transcoder output and the FEC block assembler in the fc1 KR layer.

## Interface
Parameters:
- `WPB`, 32, words per FEC block; counter width is `$clog2(WPB)`.
- `ECW`, 16, error counter width.

Ports:
- `CLK`  in  1  sole clock.
- `RST_N`  in  1  asynchronous active-low reset.
- `EN`  in  1  global enable; when low, forces IDLE and drops any block in progress without raising an error.
- `IN_VALID`  in  1  input word valid.
- `IN_SOB`  in  1  start of block; qualified by `IN_VALID`.
- `IN_DATA`  in  65  transcoded word.
- `E0_DIN`, `E1_DIN`  out  65  engine data, registered.
- `E0_ENA`, `E1_ENA`  out  1  engine enable, registered. Low clears the engine on the next edge. Engine `RST` pins are tied 0.
- `E0_CRC`, `E1_CRC`  in  32  engine state.
- `PAR_VALID`  out  1  one-cycle pulse; `PAR` is valid.
- `PAR`  out  32  block parity.
- `PAR_ENG`  out  1  engine that produced `PAR`.
- `ERR_SOB`  out  1  pulse: `IN_SOB` arrived mid-block.
- `ERR_GAP`  out  1  pulse: `IN_VALID` dropped mid-block.
- `ERR_CNT`  out  ECW  saturating count of `ERR_SOB` + `ERR_GAP` events.

## Operation
- Reset: every output and internal register is 0. State IDLE, engine select `sel` = 0.
- States: IDLE and RUN. Word counter `wcnt` runs 0..WPB-1.
- IDLE:
  - `IN_VALID & IN_SOB & EN` → accept word 0 on engine `sel`. `wcnt`=1, go to RUN.
  - `IN_VALID` without `IN_SOB` → word discarded silently (pre-alignment); no error.
- RUN:
  - `IN_VALID & ~IN_SOB` → word goes to engine `sel` and `wcnt++`.
  - On the word where `wcnt`=WPB-1: mark `sel` done, toggle `sel`, go to IDLE.
- Engine drive (registered): for an accepted word, `Ex_DIN`<=`IN_DATA` and `Ex_ENA`<=1 for engine x=`sel`. Every other case drives `Ex_ENA`<=0. `Ex_DIN` holds its last value when not loaded.
- Capture: one cycle after the last word's `Ex_ENA` cycle, `Ex_CRC` holds the parity and `Ex_ENA` is 0. `PAR`<=`Ex_CRC`, `PAR_ENG`<=x, `PAR_VALID`<=1 on that edge.
- Mid-block `IN_SOB` (RUN, `IN_VALID & IN_SOB`):
  - Abort the current engine (ENA low next cycle); that block yields no parity.
  - Pulse `ERR_SOB`.
  - Toggle `sel` and accept the word as word 0 of a new block; `wcnt`=1, stay in RUN.
- Gap (RUN, `~IN_VALID`): abort the current engine, pulse `ERR_GAP`, toggle `sel`, go to IDLE.
- `EN` low in RUN: abort the block with no error pulse, go to IDLE, keep `sel`.
- Engine-clear invariant: an engine always sees at least one ENA-low cycle before its word 0. The toggle-on-every-block rule guarantees this, including SOB-abort chains. No extra clear cycle is inserted.
- `ERR_CNT` increments by 1 per error pulse and saturates at all-ones. Two errors cannot occur in one cycle.
- Completion and a new SOB on the other engine in the same cycle: both are handled; no conflict.

## Timing
- Word 0 accepted in cycle c:
  - `Ex_ENA`/`Ex_DIN` high in cycles c+1..c+32.
  - Capture in cycle c+33.
  - `PAR_VALID` high in cycle c+34 (3 cycles after the last word).
- Throughput: gapless back-to-back blocks, one word per cycle. Parity pulses are spaced 32 cycles apart and alternate engines 0/1.
- `ERR_SOB`/`ERR_GAP` rise on the cycle after the offending input cycle.
- Async reset mid-block: all outputs drop to 0 immediately. No `PAR_VALID` for the interrupted block. The first SOB after release starts on engine 0.

## Test plan
- All-zero 32-word block starting at cycle 10 → `PAR_VALID`=1 at cycle 44 only, `PAR`=32'h00000000, `PAR_ENG`=0, no errors.
- Two back-to-back random blocks starting at cycle 10 → `PAR_VALID` at 44 (`PAR_ENG`=0) and 76 (`PAR_ENG`=1). `PAR` matches the bit-serial golden model of g(x) for each block. `E0_ENA` is low in cycles 43..75.
- `IN_VALID` dropped at word 10 → `ERR_GAP` pulse, `ERR_CNT`=1, no `PAR_VALID`. The next full block yields correct parity on engine 1.
- `IN_SOB` at word 5 → `ERR_SOB` pulse, first block dropped. The new block completes with `PAR_VALID` 34 cycles after the second SOB, `PAR_ENG`=1, correct parity.
- `RST_N` low at word 20 → all outputs 0 during reset, no `PAR_VALID`. After release, an all-zero block gives `PAR`=0 on engine 0.
- 65537 consecutive SOB-abort errors with `ECW`=16 → `ERR_CNT` holds 16'hFFFF.

Source files
------------

// File: rtl/kr_fec_parity_seq.sv
// -----------------------------------------------------------------------------
// kr_fec_parity_seq
//
// Frames a stream of 65-bit transcoded words into WPB-word FEC blocks and
// ping-pongs consecutive blocks across two external crc32_galois_d65 engines
// (g(x) = 1+x^2+x^11+x^21+x^23+x^32). Each engine is cleared by holding its
// ENA low, and the 32-bit parity is captured two cycles after the last word
// of a block has been handed to the engine.
//
// Handshake: a word is transferred in every cycle where IN_VALID is high at
// the rising CLK edge; there is no backpressure. IN_SOB is only meaningful
// together with IN_VALID. PAR_VALID is a one-cycle pulse with PAR/PAR_ENG
// holding their value afterwards.
//
// Ports:
//   CLK, RST_N          clock, asynchronous active-low reset
//   EN                  global enable; low forces IDLE and drops the block
//   IN_VALID/IN_SOB     input word valid / start of block
//   IN_DATA[64:0]       transcoded word
//   E0_/E1_DIN[64:0]    engine data (registered, held when not loaded)
//   E0_/E1_ENA          engine enable (registered); low clears the engine
//   E0_/E1_CRC[31:0]    engine state
//   PAR_VALID/PAR/PAR_ENG  parity pulse, parity value, producing engine
//   ERR_SOB/ERR_GAP     pulse: SOB mid-block / valid dropped mid-block
//   ERR_CNT[ECW-1:0]    saturating error count
//   DBG_STATE           {state, sel, wcnt} for observation
// -----------------------------------------------------------------------------
module kr_fec_parity_seq #(
    parameter int WPB = 32,
    parameter int ECW = 16
) (
    input  logic                   CLK,
    input  logic                   RST_N,
    input  logic                   EN,
    input  logic                   IN_VALID,
    input  logic                   IN_SOB,
    input  logic [64:0]            IN_DATA,
    output logic [64:0]            E0_DIN,
    output logic [64:0]            E1_DIN,
    output logic                   E0_ENA,
    output logic                   E1_ENA,
    input  logic [31:0]            E0_CRC,
    input  logic [31:0]            E1_CRC,
    output logic                   PAR_VALID,
    output logic [31:0]            PAR,
    output logic                   PAR_ENG,
    output logic                   ERR_SOB,
    output logic                   ERR_GAP,
    output logic [ECW-1:0]         ERR_CNT,
    output logic [$clog2(WPB)+1:0] DBG_STATE
);

    localparam int CW = $clog2(WPB);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t        state;
    logic          sel;       // engine receiving the current/next block
    logic [CW-1:0] wcnt;      // index of the next expected word
    logic [1:0]    last_q;    // one-hot: engine whose last word is on ENA now
    logic [1:0]    cap_q;     // one-hot: engine whose CRC holds parity now

    // next-state decode
    state_t        nstate;
    logic          nsel;
    logic [CW-1:0] nwcnt;
    logic          accept;    // IN_DATA goes to engine eng this cycle
    logic          eng;
    logic          done;      // accepted word is the last of the block
    logic          err_sob_c;
    logic          err_gap_c;

    assign DBG_STATE = {state, sel, wcnt};

    always_comb begin
        nstate    = state;
        nsel      = sel;
        nwcnt     = wcnt;
        accept    = 1'b0;
        eng       = sel;
        done      = 1'b0;
        err_sob_c = 1'b0;
        err_gap_c = 1'b0;
        case (state)
            IDLE: begin
                // Words without SOB are pre-alignment traffic: dropped quietly.
                if (EN && IN_VALID && IN_SOB) begin
                    accept = 1'b1;
                    nwcnt  = CW'(1);
                    nstate = RUN;
                end
            end
            RUN: begin
                if (!EN) begin
                    // Silent abort; the engine keeps its turn.
                    nstate = IDLE;
                    nwcnt  = '0;
                end else if (!IN_VALID) begin
                    err_gap_c = 1'b1;
                    nsel      = ~sel;
                    nstate    = IDLE;
                    nwcnt     = '0;
                end else if (IN_SOB) begin
                    // Restart on the other engine: the aborted engine sees ENA
                    // low next cycle, and the new engine has been idle since
                    // its previous block, so no extra clear cycle is needed.
                    err_sob_c = 1'b1;
                    nsel      = ~sel;
                    eng       = ~sel;
                    accept    = 1'b1;
                    nwcnt     = CW'(1);
                end else begin
                    accept = 1'b1;
                    if (wcnt == CW'(WPB - 1)) begin
                        done   = 1'b1;
                        nsel   = ~sel;
                        nstate = IDLE;
                        nwcnt  = '0;
                    end else begin
                        nwcnt = wcnt + CW'(1);
                    end
                end
            end
            default: begin
                nstate = IDLE;
                nwcnt  = '0;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state     <= IDLE;
            sel       <= 1'b0;
            wcnt      <= '0;
            last_q    <= 2'b00;
            cap_q     <= 2'b00;
            E0_DIN    <= '0;
            E1_DIN    <= '0;
            E0_ENA    <= 1'b0;
            E1_ENA    <= 1'b0;
            PAR_VALID <= 1'b0;
            PAR       <= '0;
            PAR_ENG   <= 1'b0;
            ERR_SOB   <= 1'b0;
            ERR_GAP   <= 1'b0;
            ERR_CNT   <= '0;
        end else begin
            state <= nstate;
            sel   <= nsel;
            wcnt  <= nwcnt;

            E0_ENA <= accept & ~eng;
            E1_ENA <= accept & eng;
            if (accept && !eng) E0_DIN <= IN_DATA;
            if (accept && eng)  E1_DIN <= IN_DATA;

            // last word on ENA -> engine state settles -> capture
            last_q <= {done & sel, done & ~sel};
            cap_q  <= last_q;

            PAR_VALID <= |cap_q;
            if (cap_q[0]) begin
                PAR     <= E0_CRC;
                PAR_ENG <= 1'b0;
            end else if (cap_q[1]) begin
                PAR     <= E1_CRC;
                PAR_ENG <= 1'b1;
            end

            ERR_SOB <= err_sob_c;
            ERR_GAP <= err_gap_c;
            if ((err_sob_c || err_gap_c) && (ERR_CNT != {ECW{1'b1}}))
                ERR_CNT <= ERR_CNT + ECW'(1);
        end
    end

endmodule

// File: tb/tb_kr_fec_parity_seq.sv
// -----------------------------------------------------------------------------
// tb_kr_fec_parity_seq
//
// Directed bench for kr_fec_parity_seq. Two bench-side CRC engines sit on the
// E0/E1 ports. A block-level model tracks framing from the input stream and
// computes block parity by polynomial long division over the whole block
// bitstream; expected parities wait in exp_q until their PAR_VALID cycle.
// -----------------------------------------------------------------------------
module tb_kr_fec_parity_seq;

    localparam int WPB = 32;
    localparam int ECW = 16;
    localparam int NB  = WPB * 65;
    localparam logic [31:0] POLY = 32'h00A00805;
    localparam int CNT_MAX = (1 << ECW) - 1;

    // ---------------- clock / reset ----------------
    logic CLK = 1'b0;
    logic RST_N = 1'b1;
    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    // ---------------- DUT ----------------
    logic            EN = 1'b1;
    logic            IN_VALID = 1'b0;
    logic            IN_SOB = 1'b0;
    logic [64:0]     IN_DATA = '0;
    logic [64:0]     E0_DIN, E1_DIN;
    logic            E0_ENA, E1_ENA;
    logic [31:0]     E0_CRC, E1_CRC;
    logic            PAR_VALID;
    logic [31:0]     PAR;
    logic            PAR_ENG;
    logic            ERR_SOB, ERR_GAP;
    logic [ECW-1:0]  ERR_CNT;
    logic [6:0]      DBG_STATE;

    kr_fec_parity_seq #(.WPB(WPB), .ECW(ECW)) dut (
        .CLK(CLK), .RST_N(RST_N), .EN(EN),
        .IN_VALID(IN_VALID), .IN_SOB(IN_SOB), .IN_DATA(IN_DATA),
        .E0_DIN(E0_DIN), .E1_DIN(E1_DIN), .E0_ENA(E0_ENA), .E1_ENA(E1_ENA),
        .E0_CRC(E0_CRC), .E1_CRC(E1_CRC),
        .PAR_VALID(PAR_VALID), .PAR(PAR), .PAR_ENG(PAR_ENG),
        .ERR_SOB(ERR_SOB), .ERR_GAP(ERR_GAP), .ERR_CNT(ERR_CNT),
        .DBG_STATE(DBG_STATE)
    );

    // ---------------- bench-side engines (RST tied 0) ----------------
    function automatic logic [31:0] step65(input logic [31:0] c, input logic [64:0] d);
        logic [31:0] r;
        logic fb;
        r = c;
        for (int i = 64; i >= 0; i--) begin
            fb = r[31] ^ d[i];
            r  = {r[30:0], 1'b0};
            if (fb) r = r ^ POLY;
        end
        return r;
    endfunction

    logic [31:0] e0_crc = '0;
    logic [31:0] e1_crc = '0;
    always @(posedge CLK) begin
        e0_crc <= E0_ENA ? step65(e0_crc, E0_DIN) : 32'h0;
        e1_crc <= E1_ENA ? step65(e1_crc, E1_DIN) : 32'h0;
    end
    assign E0_CRC = e0_crc;
    assign E1_CRC = e1_crc;

    // ---------------- golden parity: M(x)*x^32 mod g(x) ----------------
    function automatic logic [31:0] golden(input logic [64:0] w [WPB]);
        logic        r [NB + 32];
        logic [32:0] g;
        logic [31:0] res;
        g = {1'b1, POLY};
        for (int i = 0; i < NB; i++) r[i] = w[i / 65][64 - (i % 65)];
        for (int i = NB; i < NB + 32; i++) r[i] = 1'b0;
        for (int i = 0; i < NB; i++)
            if (r[i])
                for (int j = 0; j <= 32; j++) r[i + j] = r[i + j] ^ g[32 - j];
        for (int k = 0; k < 32; k++) res[31 - k] = r[NB + k];
        return res;
    endfunction

    // ---------------- scoreboard ----------------
    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [64:0] act, input logic [64:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @cyc %0d: got %h expected %h", nm, cyc, act, exp);
        end
    endtask

    logic [31:0] exp_q[$];
    logic        exp_eng_q[$];
    int          exp_cyc_q[$];

    // block-level model state
    logic        m_run = 1'b0;
    logic        m_sel = 1'b0;
    int          m_n = 0;
    logic [64:0] m_words [WPB];
    logic        m_ena0 = 1'b0, m_ena1 = 1'b0;
    logic [64:0] m_din0 = '0, m_din1 = '0;
    logic        m_esob = 1'b0, m_egap = 1'b0;
    int          m_errs = 0;
    logic [31:0] m_par = '0;
    logic        m_peng = 1'b0;

    task automatic model_clear();
        m_run = 1'b0; m_sel = 1'b0; m_n = 0;
        m_ena0 = 1'b0; m_ena1 = 1'b0; m_din0 = '0; m_din1 = '0;
        m_esob = 1'b0; m_egap = 1'b0; m_errs = 0;
        m_par = '0; m_peng = 1'b0;
        exp_q.delete(); exp_eng_q.delete(); exp_cyc_q.delete();
    endtask

    // consumes this cycle's inputs, sets expectations for the next cycle
    task automatic model_step();
        logic acc, aeng, e_s, e_g;
        acc = 1'b0; aeng = m_sel; e_s = 1'b0; e_g = 1'b0;
        if (!m_run) begin
            if (IN_VALID && IN_SOB && EN) begin
                acc = 1'b1; m_n = 0; m_run = 1'b1;
            end
        end else if (!EN) begin
            m_run = 1'b0;
        end else if (!IN_VALID) begin
            e_g = 1'b1; m_sel = ~m_sel; m_run = 1'b0;
        end else if (IN_SOB) begin
            e_s = 1'b1; m_sel = ~m_sel; aeng = m_sel; acc = 1'b1; m_n = 0;
        end else begin
            acc = 1'b1;
        end
        if (acc) begin
            m_words[m_n] = IN_DATA;
            m_n++;
            if (aeng) m_din1 = IN_DATA; else m_din0 = IN_DATA;
        end
        if (acc && m_n == WPB) begin
            exp_q.push_back(golden(m_words));
            exp_eng_q.push_back(aeng);
            exp_cyc_q.push_back(cyc + 3);
            m_sel = ~m_sel; m_run = 1'b0; m_n = 0;
        end
        m_ena0 = acc && !aeng;
        m_ena1 = acc && aeng;
        m_esob = e_s;
        m_egap = e_g;
        if ((e_s || e_g) && m_errs < CNT_MAX) m_errs++;
    endtask

    // observed parity pulses, for the directed literal checks
    int          pv_count = 0;
    int          last_pv_cyc = 0;
    logic [31:0] last_pv_par = '0;
    logic        last_pv_eng = 1'b0;

    // ---------------- compare process ----------------
    always @(negedge CLK) begin
        if (!RST_N) begin
            chk("rst_e0_ena", E0_ENA, 0);
            chk("rst_e1_ena", E1_ENA, 0);
            chk("rst_e0_din", E0_DIN, 0);
            chk("rst_e1_din", E1_DIN, 0);
            chk("rst_par_valid", PAR_VALID, 0);
            chk("rst_par", PAR, 0);
            chk("rst_par_eng", PAR_ENG, 0);
            chk("rst_err_sob", ERR_SOB, 0);
            chk("rst_err_gap", ERR_GAP, 0);
            chk("rst_err_cnt", ERR_CNT, 0);
            model_clear();
        end else begin
            logic exp_pv;
            exp_pv = 1'b0;
            if (exp_cyc_q.size() != 0 && exp_cyc_q[0] == cyc) begin
                exp_pv = 1'b1;
                m_par  = exp_q.pop_front();
                m_peng = exp_eng_q.pop_front();
                void'(exp_cyc_q.pop_front());
            end
            chk("e0_ena", E0_ENA, m_ena0);
            chk("e1_ena", E1_ENA, m_ena1);
            chk("e0_din", E0_DIN, m_din0);
            chk("e1_din", E1_DIN, m_din1);
            chk("par_valid", PAR_VALID, exp_pv);
            chk("par", PAR, m_par);
            chk("par_eng", PAR_ENG, m_peng);
            chk("err_sob", ERR_SOB, m_esob);
            chk("err_gap", ERR_GAP, m_egap);
            chk("err_cnt", ERR_CNT, m_errs);
            if (PAR_VALID) begin
                pv_count++;
                last_pv_cyc = cyc;
                last_pv_par = PAR;
                last_pv_eng = PAR_ENG;
            end
            model_step();
        end
    end

    // ---------------- driver tasks ----------------
    int sob_cyc = 0;

    task automatic send_word(input logic v, input logic s, input logic [64:0] d);
        @(posedge CLK);
        #1;
        IN_VALID = v;
        IN_SOB   = s;
        IN_DATA  = d;
    endtask

    task automatic idle(input int n);
        repeat (n) send_word(1'b0, 1'b0, '0);
    endtask

    function automatic logic [64:0] rand_word();
        logic [64:0] d;
        d[31:0]  = $urandom;
        d[63:32] = $urandom;
        d[64]    = ($urandom_range(0, 1) == 1);
        return d;
    endfunction

    // mode 0: all zero, 1: random, 2: single 1 in the last bit of the block
    task automatic send_block(input int nw, input int mode);
        logic [64:0] d;
        for (int i = 0; i < nw; i++) begin
            case (mode)
                1:       d = rand_word();
                2:       d = (i == WPB - 1) ? 65'd1 : 65'd0;
                default: d = '0;
            endcase
            send_word(1'b1, i == 0, d);
            if (i == 0) sob_cyc = cyc;
        end
    endtask

    task automatic do_reset(input int n);
        @(posedge CLK);
        #1;
        RST_N = 1'b0;
        IN_VALID = 1'b0;
        IN_SOB = 1'b0;
        EN = 1'b1;
        repeat (n) @(posedge CLK);
        #1;
        RST_N = 1'b1;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        logic [64:0] tw [WPB];
        int pv0, sob1;

        // pin the golden model with hand-derived remainders
        for (int i = 0; i < WPB; i++) tw[i] = '0;
        chk("gold_zero", golden(tw), 32'h0);
        tw[WPB-1] = 65'd1;
        chk("gold_x32", golden(tw), 32'h00A00805);
        tw[WPB-1] = 65'd2;
        chk("gold_x33", golden(tw), 32'h0140100A);

        do_reset(3);
        chk("dbg_after_reset", DBG_STATE, 0);

        // all-zero block
        idle(4);
        pv0 = pv_count;
        send_block(WPB, 0);
        idle(6);
        chk("zero_pv_cnt", pv_count - pv0, 1);
        chk("zero_latency", last_pv_cyc - sob_cyc, 34);
        chk("zero_par", last_pv_par, 32'h0);
        chk("zero_eng", last_pv_eng, 0);

        // two back-to-back random blocks
        do_reset(2);
        idle(4);
        pv0 = pv_count;
        send_block(WPB, 1);
        sob1 = sob_cyc;
        send_block(WPB, 1);
        idle(6);
        chk("b2b_pv_cnt", pv_count - pv0, 2);
        chk("b2b_latency2", last_pv_cyc - sob1, 66);
        chk("b2b_eng2", last_pv_eng, 1);

        // gap at word 10, then a full block on engine 1
        do_reset(2);
        idle(2);
        pv0 = pv_count;
        send_block(10, 1);
        idle(40);
        chk("gap_err_cnt", ERR_CNT, 1);
        chk("gap_no_pv", pv_count - pv0, 0);
        send_block(WPB, 1);
        idle(6);
        chk("gap_next_eng", last_pv_eng, 1);
        chk("gap_next_pv", pv_count - pv0, 1);

        // SOB at word 5
        do_reset(2);
        idle(2);
        pv0 = pv_count;
        send_block(5, 1);
        send_block(WPB, 1);
        idle(6);
        chk("sob_err_cnt", ERR_CNT, 1);
        chk("sob_pv_cnt", pv_count - pv0, 1);
        chk("sob_latency", last_pv_cyc - sob_cyc, 34);
        chk("sob_eng", last_pv_eng, 1);

        // reset at word 20, then zero block, then single-bit block
        do_reset(2);
        idle(2);
        pv0 = pv_count;
        send_block(20, 1);
        do_reset(3);
        idle(40);
        chk("rst_mid_no_pv", pv_count - pv0, 0);
        send_block(WPB, 0);
        idle(6);
        chk("rst_zero_par", last_pv_par, 32'h0);
        chk("rst_zero_eng", last_pv_eng, 0);
        send_block(WPB, 2);
        idle(6);
        chk("x32_par", last_pv_par, 32'h00A00805);
        chk("x32_eng", last_pv_eng, 1);

        // EN dropped mid-block: silent abort
        do_reset(2);
        idle(2);
        pv0 = pv_count;
        send_block(7, 1);
        @(posedge CLK);
        #1;
        EN = 1'b0;
        IN_VALID = 1'b1;
        IN_SOB = 1'b0;
        @(posedge CLK);
        #1;
        EN = 1'b1;
        IN_VALID = 1'b0;
        idle(40);
        chk("en_err_cnt", ERR_CNT, 0);
        chk("en_no_pv", pv_count - pv0, 0);

        // 65537 consecutive SOB aborts saturate the counter
        do_reset(2);
        idle(2);
        for (int i = 0; i < 65538; i++) send_word(1'b1, 1'b1, rand_word());
        idle(4);
        chk("sat_err_cnt", ERR_CNT, 16'hFFFF);

        idle(4);
        chk("exp_q_drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
